// File: rtl/hfifo_pkg.sv
// ============================================================================
// Module      : hfifo_pkg
// Description : Shared widths, flag bundle and flag helper for hfifo_thr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hfifo_pkg;

  localparam int C_DEF_DEPTH = 16;
  localparam int C_DEF_PTR_W = $clog2(C_DEF_DEPTH);
  localparam int C_DEF_LVL_W = C_DEF_PTR_W + 1;

  typedef struct packed {
    logic rdy;
    logic not_full;
    logic almost_full;
    logic almost_empty;
  } hfifo_flags_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Occupancy flags for a given level; used for both next-state and reset values.
  function automatic hfifo_flags_t flags_for(input int lvl, input int depth,
                                             input int af, input int ae);
    hfifo_flags_t f;
    f.rdy          = (lvl != 0);
    f.not_full     = (lvl != depth);
    f.almost_full  = (lvl >= af);
    f.almost_empty = (lvl <= ae);
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hfifo_mem.sv
// ============================================================================
// Module      : hfifo_mem
// Description : FIFO storage, one sync write port, one async read port, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hfifo_mem #(
  parameter int DEPTH  = 16,
  parameter int DWIDTH = 8,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/hfifo_thr.sv
// ============================================================================
// Module      : hfifo_thr
// Description : First-word fall-through FIFO with registered level/threshold
//               flags. Define HFIFO_THR_ERR_EN to build sticky overflow and
//               underflow flags; otherwise they are tied low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hfifo_thr
  import hfifo_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int DWIDTH   = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DWIDTH-1:0]        din,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr_err,
  output logic [DWIDTH-1:0]        dout,
  output logic                     rdy,
  output logic                     not_full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int C_PTR_W = ptr_w(DEPTH);
  localparam int C_LVL_W = lvl_w(DEPTH);
  localparam logic [C_LVL_W-1:0] C_DEPTH_L = C_LVL_W'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("hfifo_thr: DEPTH must be a power of two >= 2");
  end
  if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_chk_levels
    $error("hfifo_thr: require AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [C_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [C_LVL_W-1:0] r_level, w_level_nxt;
  hfifo_flags_t       r_flags, w_flags_nxt;
  logic               w_full, w_empty, w_do_push, w_do_pop;

  assign w_full    = (r_level == C_DEPTH_L);
  assign w_empty   = (r_level == '0);
  assign w_do_pop  = pop && !w_empty;
  // When full, a simultaneous pop frees the slot being written this edge.
  assign w_do_push = push && (!w_full || pop);

  always_comb begin
    w_level_nxt = r_level;
    case ({w_do_push, w_do_pop})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase
  end

  assign w_flags_nxt = flags_for(int'(w_level_nxt), DEPTH, AF_LEVEL, AE_LEVEL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_flags  <= flags_for(0, DEPTH, AF_LEVEL, AE_LEVEL);
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_nxt;
      r_flags <= w_flags_nxt;
    end
  end

  hfifo_mem #(
    .DEPTH  (DEPTH),
    .DWIDTH (DWIDTH),
    .AW     (C_PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_do_push),
    .waddr (r_wr_ptr),
    .wdata (din),
    .raddr (r_rd_ptr),
    .rdata (dout)
  );

`ifdef HFIFO_THR_ERR_EN
  logic r_overflow, r_underflow;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clr_err) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (push && w_full && !pop) r_overflow  <= 1'b1;
      if (pop && w_empty)         r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  logic w_unused_clr;
  assign w_unused_clr = clr_err;
  assign overflow     = 1'b0;
  assign underflow    = 1'b0;
`endif

  assign level        = r_level;
  assign rdy          = r_flags.rdy;
  assign not_full     = r_flags.not_full;
  assign almost_full  = r_flags.almost_full;
  assign almost_empty = r_flags.almost_empty;

endmodule

`default_nettype wire

// File: tb/tb_hfifo_thr.sv
// ============================================================================
// Module      : tb_hfifo_thr
// Description : Directed self-checking bench for hfifo_thr (DEPTH=16, DWIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hfifo_thr;

`ifdef HFIFO_THR_ERR_EN
  localparam logic C_ERR = 1'b1;
`else
  localparam logic C_ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] din = '0;
  logic       push = 1'b0, pop = 1'b0, clr_err = 1'b0;
  logic [7:0] dout;
  logic       rdy, not_full, almost_full, almost_empty, overflow, underflow;
  logic [4:0] level;

  int n_checks = 0;
  int n_fail   = 0;

  hfifo_thr #(.DEPTH(16), .DWIDTH(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .din          (din),
    .push         (push),
    .pop          (pop),
    .clr_err      (clr_err),
    .dout         (dout),
    .rdy          (rdy),
    .not_full     (not_full),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #1;
    check("rst_level", 32'(level), 0);
    check("rst_rdy", 32'(rdy), 0);
    check("rst_not_full", 32'(not_full), 1);
    check("rst_af", 32'(almost_full), 0);
    check("rst_ae", 32'(almost_empty), 1);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_udf", 32'(underflow), 0);
    #4 reset_n = 1'b1;
    step();

    // Fill 0x00..0x0F
    push = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din = 8'(i);
      step();
      check("fill_level", 32'(level), i + 1);
      check("fill_af", 32'(almost_full), ((i + 1) >= 14) ? 1 : 0);
      check("fill_ae", 32'(almost_empty), ((i + 1) <= 2) ? 1 : 0);
      check("fill_not_full", 32'(not_full), ((i + 1) != 16) ? 1 : 0);
      if (i == 0) begin
        check("fill_first_rdy", 32'(rdy), 1);
        check("fill_first_dout", 32'(dout), 0);
      end
    end
    push = 1'b0;

    // Drain and check order
    pop = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_dout", 32'(dout), i);
      step();
      check("drain_level", 32'(level), 15 - i);
      check("drain_ae", 32'(almost_empty), ((15 - i) <= 2) ? 1 : 0);
    end
    pop = 1'b0;
    check("drain_rdy", 32'(rdy), 0);

    // Refill with 0x40..0x4F, then streaming push+pop across pointer wrap
    push = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din = 8'(8'h40 + i);
      step();
    end
    check("refill_level", 32'(level), 16);
    pop = 1'b1;
    for (int k = 0; k < 20; k++) begin
      din = 8'(8'h50 + k);
      check("stream_dout", 32'(dout), (k < 16) ? (8'h40 + k) : (8'h50 + k - 16));
      step();
      check("stream_level", 32'(level), 16);
    end
    pop = 1'b0;
    check("stream_ovf", 32'(overflow), 0);

    // Push while full: ignored, overflow set
    din = 8'hEE;
    step();
    push = 1'b0;
    check("ovf_set", 32'(overflow), 32'(C_ERR));
    check("ovf_level", 32'(level), 16);
    check("ovf_head", 32'(dout), 8'h54);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("ovf_clr", 32'(overflow), 0);
    pop = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("ovf_contents", 32'(dout), 8'h54 + i);
      step();
    end
    pop = 1'b0;
    check("ovf_empty", 32'(rdy), 0);

    // Empty with push+pop: push taken, pop ignored
    push = 1'b1; pop = 1'b1; din = 8'hA5;
    step();
    push = 1'b0; pop = 1'b0;
    check("pp_rdy", 32'(rdy), 1);
    check("pp_dout", 32'(dout), 8'hA5);
    check("pp_level", 32'(level), 1);
    check("pp_udf", 32'(underflow), 32'(C_ERR));
    clr_err = 1'b1; pop = 1'b1;
    step();
    clr_err = 1'b0; pop = 1'b0;
    check("pp_udf_clr", 32'(underflow), 0);
    check("pp_drained", 32'(level), 0);

    // Asynchronous reset mid-stream
    push = 1'b1;
    for (int i = 0; i < 7; i++) begin
      din = 8'(8'h70 + i);
      step();
    end
    push = 1'b0;
    check("mid_level", 32'(level), 7);
    #2 reset_n = 1'b0;
    #1;
    check("async_level", 32'(level), 0);
    check("async_rdy", 32'(rdy), 0);
    #2 reset_n = 1'b1;
    push = 1'b1; din = 8'h3C;
    step();
    push = 1'b0;
    check("post_rst_rdy", 32'(rdy), 1);
    check("post_rst_dout", 32'(dout), 8'h3C);
    check("post_rst_level", 32'(level), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
